// File: rtl/seq_counter_ctrl.sv
// Sequencer for the arbitrary-sequence counter datapath.
// Holds a writable table of count values and steps an index through it.
// Supports run, pause and single-step modes with a programmable sequence length.
// All state updates happen on the falling edge of C.
module seq_counter_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned AW    = 4
) (
    input  logic             C,
    input  logic             R,
    input  logic             clr,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic [AW-1:0]    len_m1,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] Q,
    output logic [AW-1:0]    idx,
    output logic             running,
    output logic             wrap
);

    localparam int unsigned Depth = 2 ** AW;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] table_q [Depth];

    logic             advance;
    logic             at_last;
    logic [AW-1:0]    idx_inc;

    // At or past the last valid index; covers len_m1 shrinking below idx mid-run.
    assign at_last = (idx_q >= len_m1);
    assign idx_inc = idx_q + AW'(1);

    // State register: reset forces IDLE, otherwise take the decoded next state.
    always_ff @(negedge C) begin
        if (R) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode with priority clr > stop > start > step.
    always_comb begin
        state_d = state_q;
        advance = 1'b0;
        if (clr) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // stop has no meaning here, so start/step decide the edge
                    if (start) begin
                        state_d = StRun;
                    end else if (step) begin
                        advance = 1'b1;
                    end
                end
                StRun: begin
                    if (stop) begin
                        state_d = StPause;
                    end else begin
                        advance = 1'b1;
                    end
                end
                StPause: begin
                    if (start) begin
                        state_d = StRun;
                    end else if (step) begin
                        advance = 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Index, wrap flag and next count value; a same-edge write to the new index bypasses the table.
    always_comb begin
        idx_d  = idx_q;
        wrap_d = 1'b0;
        if (clr) begin
            idx_d = '0;
        end else if (advance) begin
            if (at_last) begin
                idx_d  = '0;
                wrap_d = 1'b1;
            end else begin
                idx_d = idx_inc;
            end
        end
        if (wr_en && (wr_addr == idx_d)) begin
            q_d = wr_data;
        end else begin
            q_d = table_q[idx_d];
        end
    end

    // Datapath registers: index, output value and wrap pulse.
    always_ff @(negedge C) begin
        if (R) begin
            idx_q  <= '0;
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    // Count table: reset loads the identity sequence, a write strobe updates one entry.
    always_ff @(negedge C) begin
        if (R) begin
            for (int i = 0; i < Depth; i++) begin
                table_q[i] <= WIDTH'(i);
            end
        end else if (wr_en) begin
            table_q[wr_addr] <= wr_data;
        end
    end

    // Outputs decoded from the registered state.
    always_comb begin
        running = (state_q == StRun);
        Q       = q_q;
        idx     = idx_q;
        wrap    = wrap_q;
    end

endmodule
